// File: rtl/ysyx_22050598_defines_pkg.sv
// Shared definitions for the instruction cache controller: FSM encoding,
// line/set geometry and the word-select helper.
package ysyx_22050598_defines;

  localparam int LINE_BYTES = 16;
  localparam int SET_NUM    = 64;
  localparam int INDEX_W    = 6;
  localparam int OFFSET_W   = 4;
  localparam int BEAT_W     = 64;
  localparam int LINE_W     = 128;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOOKUP = 3'd1,
    S_MISS   = 3'd2,
    S_REFILL = 3'd3,
    S_UPDATE = 3'd4,
    S_RESP   = 3'd5,
    S_FLUSH  = 3'd6
  } state_t;

  function automatic logic [31:0] word_sel(input logic [LINE_W-1:0] line,
                                           input logic [1:0] word);
    return line[{word, 5'b0} +: 32];
  endfunction

endpackage

// File: rtl/ysyx_22050598_icache_refill_buf.sv
// Two-beat line assembler: beat 0 fills line[63:0], beat 1 fills line[127:64].
// The line completes on the second accepted beat whatever mem_rsp_last says.
module ysyx_22050598_icache_refill_buf
  import ysyx_22050598_defines::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              beat_valid,
  input  logic [BEAT_W-1:0] beat_data,
  input  logic              beat_last,
  output logic [LINE_W-1:0] line,
  output logic              done,
  output logic              proto_err
);

  logic beat_cnt;

  assign done      = en & beat_valid & beat_cnt;
  // last flag disagreeing with the beat count is reported but never acted on
  assign proto_err = en & beat_valid & (beat_last ^ beat_cnt);

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt <= 1'b0;
      line     <= '0;
    end else if (en && beat_valid) begin
      beat_cnt <= ~beat_cnt;
      if (beat_cnt) line[LINE_W-1:BEAT_W] <= beat_data;
      else          line[BEAT_W-1:0]      <= beat_data;
    end
  end

endmodule

// File: rtl/ysyx_22050598_icache_ctrl.sv
// Blocking instruction cache controller (tag/data arrays live outside).
// Define YSYX_22050598_ICACHE_FENCE_EN to make fence_i invalidate all 64 sets.
module ysyx_22050598_icache_ctrl
  import ysyx_22050598_defines::*;
#(
  parameter int ADDR_W = 32,
  parameter int TAG_W  = 22,
  parameter int DW     = 23
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req_valid,
  output logic              cpu_req_ready,
  input  logic [ADDR_W-1:0] cpu_req_addr,
  output logic              cpu_rsp_valid,
  input  logic              cpu_rsp_ready,
  output logic [31:0]       cpu_rsp_data,
  output logic              tag_wen,
  output logic [5:0]        tag_set_index,
  output logic [DW-1:0]     tag_wdata,
  input  logic [DW-1:0]     tag_rdata,
  output logic              data_wen,
  output logic [5:0]        data_set_index,
  output logic [127:0]      data_wdata,
  input  logic [127:0]      data_rdata,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_rsp_valid,
  input  logic [63:0]       mem_rsp_data,
  input  logic              mem_rsp_last,
  input  logic              fence_i,
  output logic              fence_done,
  output logic [2:0]        dbg_state,
  output logic [1:0]        dbg_flags
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both 1; valid-side payload stays stable from valid rising until that edge.

  state_t               state, state_nxt;
  logic [ADDR_W-1:2]    addr_q;
  logic [31:0]          rsp_data_q;
  logic                 fence_done_q;
  logic [LINE_W-1:0]    line;
  logic                 refill_done, proto_err, hit, fence_go;
  logic [TAG_W-1:0]     tag_q;
  logic [INDEX_W-1:0]   index_q;
  logic [1:0]           word_q;

  assign tag_q   = addr_q[10 +: TAG_W];
  assign index_q = addr_q[9:4];
  assign word_q  = addr_q[3:2];
  assign hit     = tag_rdata[DW-1] & (tag_rdata[TAG_W-1:0] == tag_q);
  // while the done pulse is out, a still-high fence_i is the same request
  assign fence_go = fence_i & ~fence_done_q;

  ysyx_22050598_icache_refill_buf u_refill_buf (
    .clk        (clk),
    .rst        (rst),
    .en         (state == S_REFILL),
    .beat_valid (mem_rsp_valid),
    .beat_data  (mem_rsp_data),
    .beat_last  (mem_rsp_last),
    .line       (line),
    .done       (refill_done),
    .proto_err  (proto_err)
  );

`ifdef YSYX_22050598_ICACHE_FENCE_EN
  logic [INDEX_W-1:0] flush_cnt;

  always_ff @(posedge clk) begin
    if (rst)                   flush_cnt <= '0;
    else if (state == S_FLUSH) flush_cnt <= flush_cnt + 1'b1;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
`ifdef YSYX_22050598_ICACHE_FENCE_EN
        if (fence_go)                           state_nxt = S_FLUSH;
        else
`endif
        if (cpu_req_valid && cpu_req_ready)     state_nxt = S_LOOKUP;
      end
      S_LOOKUP: state_nxt = hit ? S_RESP : S_MISS;
      S_MISS:   if (mem_req_ready) state_nxt = S_REFILL;
      S_REFILL: if (refill_done)   state_nxt = S_UPDATE;
      S_UPDATE: state_nxt = S_RESP;
      S_RESP:   if (cpu_rsp_ready) state_nxt = S_IDLE;
`ifdef YSYX_22050598_ICACHE_FENCE_EN
      S_FLUSH:  if (flush_cnt == 6'd63) state_nxt = S_IDLE;
`else
      S_FLUSH:  state_nxt = S_IDLE;
`endif
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    cpu_req_ready = 1'b0;
    cpu_rsp_valid = 1'b0;
    mem_req_valid = 1'b0;
    tag_wen       = 1'b0;
    tag_set_index = index_q;
    tag_wdata     = '0;
    data_wen      = 1'b0;
    case (state)
      S_IDLE:   cpu_req_ready = ~fence_i;
      S_MISS:   mem_req_valid = 1'b1;
      S_UPDATE: begin
        tag_wen   = 1'b1;
        tag_wdata = {1'b1, tag_q};
        data_wen  = 1'b1;
      end
      S_RESP:   cpu_rsp_valid = 1'b1;
`ifdef YSYX_22050598_ICACHE_FENCE_EN
      S_FLUSH: begin
        tag_wen       = 1'b1;
        tag_set_index = flush_cnt;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q       <= '0;
      rsp_data_q   <= '0;
      fence_done_q <= 1'b0;
    end else begin
      fence_done_q <= 1'b0;
      case (state)
        S_IDLE: begin
`ifndef YSYX_22050598_ICACHE_FENCE_EN
          if (fence_go) fence_done_q <= 1'b1;
`endif
          if (cpu_req_valid && cpu_req_ready) addr_q <= cpu_req_addr[ADDR_W-1:2];
        end
        S_LOOKUP: if (hit) rsp_data_q <= word_sel(data_rdata, word_q);
        S_UPDATE: rsp_data_q <= word_sel(line, word_q);
`ifdef YSYX_22050598_ICACHE_FENCE_EN
        S_FLUSH:  if (flush_cnt == 6'd63) fence_done_q <= 1'b1;
`endif
        default: ;
      endcase
    end
  end

  assign cpu_rsp_data   = rsp_data_q;
  assign mem_req_addr   = {addr_q[ADDR_W-1:4], 4'b0};
  assign data_set_index = index_q;
  assign data_wdata     = line;
  assign fence_done     = fence_done_q;
  assign dbg_state      = state;
  assign dbg_flags      = {proto_err, cpu_req_valid & (|cpu_req_addr[1:0])};

endmodule

// File: tb/tb_ysyx_22050598_icache_ctrl.sv
// Directed bench for the icache controller with behavioural tag/data arrays
// and a scripted memory responder.
module tb_ysyx_22050598_icache_ctrl;

  logic         clk, rst;
  logic         cpu_req_valid, cpu_req_ready, cpu_rsp_valid, cpu_rsp_ready;
  logic [31:0]  cpu_req_addr, cpu_rsp_data;
  logic         tag_wen, data_wen;
  logic [5:0]   tag_set_index, data_set_index;
  logic [22:0]  tag_wdata, tag_rdata;
  logic [127:0] data_wdata, data_rdata;
  logic         mem_req_valid, mem_req_ready, mem_rsp_valid, mem_rsp_last;
  logic [31:0]  mem_req_addr;
  logic [63:0]  mem_rsp_data;
  logic         fence_i, fence_done;
  logic [2:0]   dbg_state;
  logic [1:0]   dbg_flags;

  ysyx_22050598_icache_ctrl dut (
    .clk(clk), .rst(rst),
    .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
    .cpu_req_addr(cpu_req_addr), .cpu_rsp_valid(cpu_rsp_valid),
    .cpu_rsp_ready(cpu_rsp_ready), .cpu_rsp_data(cpu_rsp_data),
    .tag_wen(tag_wen), .tag_set_index(tag_set_index), .tag_wdata(tag_wdata),
    .tag_rdata(tag_rdata), .data_wen(data_wen), .data_set_index(data_set_index),
    .data_wdata(data_wdata), .data_rdata(data_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data(mem_rsp_data), .mem_rsp_last(mem_rsp_last),
    .fence_i(fence_i), .fence_done(fence_done),
    .dbg_state(dbg_state), .dbg_flags(dbg_flags)
  );

`ifdef YSYX_22050598_ICACHE_FENCE_EN
  localparam int   FENCE_LAT   = 65;
  localparam int   FENCE_WR    = 64;
  localparam [2:0] FENCE_STATE = 3'd6;
`else
  localparam int   FENCE_LAT   = 1;
  localparam int   FENCE_WR    = 0;
  localparam [2:0] FENCE_STATE = 3'd0;
`endif

  typedef struct {
    logic [31:0] addr;
    logic [63:0] b0;
    logic [63:0] b1;
    logic        miss;
    logic [31:0] data;
    logic [31:0] maddr;
    logic [5:0]  set;
    logic [22:0] twd;
    int          rdelay;
    int          hold;
  } vec_t;

  int checks = 0;
  int errors = 0;

  logic [22:0]  tag_mem  [64];
  logic [127:0] data_mem [64];
  int           tag_wr_count = 0, data_wr_count = 0, zero_seq = 0;
  logic [5:0]   last_set;
  logic [22:0]  last_wdata;

  logic [63:0]  cur_b0, cur_b1;
  logic [31:0]  cur_maddr, mem_seen_addr;
  int           cur_rdelay = 0, mem_req_count = 0;
  bit           abort_after_beat0 = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  assign tag_rdata  = tag_mem[tag_set_index];
  assign data_rdata = data_mem[data_set_index];

  always @(posedge clk) begin
    if (tag_wen) begin
      tag_mem[tag_set_index] <= tag_wdata;
      tag_wr_count++;
      last_set   = tag_set_index;
      last_wdata = tag_wdata;
      if (tag_wdata == 23'd0 && tag_set_index == zero_seq[5:0]) zero_seq++;
    end
    if (data_wen) begin
      data_mem[data_set_index] <= data_wdata;
      data_wr_count++;
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // memory responder: optional ready delay, then two beats (last on beat 1)
  initial begin
    mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_last = 0; mem_rsp_data = '0;
    forever begin
      @(negedge clk);
      if (mem_req_valid && !rst) begin
        for (int i = 0; i < cur_rdelay; i++) begin
          check("mem_addr_stable", mem_req_addr, cur_maddr);
          @(negedge clk);
        end
        mem_req_ready = 1;
        mem_seen_addr = mem_req_addr;
        mem_req_count++;
        @(negedge clk);
        mem_req_ready = 0;
        mem_rsp_valid = 1; mem_rsp_data = cur_b0; mem_rsp_last = 0;
        @(negedge clk);
        if (abort_after_beat0) begin
          mem_rsp_valid = 0;
        end else begin
          mem_rsp_data = cur_b1; mem_rsp_last = 1;
          @(negedge clk);
          mem_rsp_valid = 0; mem_rsp_last = 0;
        end
      end
    end
  end

  task automatic run_vec(input int idx, input vec_t v);
    int n, tw0, dw0, mr0;
    cur_b0 = v.b0; cur_b1 = v.b1; cur_maddr = v.maddr; cur_rdelay = v.rdelay;
    tw0 = tag_wr_count; dw0 = data_wr_count; mr0 = mem_req_count;
    @(negedge clk);
    check($sformatf("v%0d_req_ready", idx), cpu_req_ready, 1'b1);
    cpu_req_valid = 1; cpu_req_addr = v.addr;
    @(posedge clk); #1;
    cpu_req_valid = 0; cpu_req_addr = $urandom;
    n = 0;
    do begin @(negedge clk); n++; end while (!cpu_rsp_valid && n < 60);
    check($sformatf("v%0d_rsp_seen", idx), cpu_rsp_valid, 1'b1);
    check($sformatf("v%0d_latency", idx), n, v.miss ? 6 + v.rdelay : 2);
    check($sformatf("v%0d_rsp_data", idx), cpu_rsp_data, v.data);
    for (int i = 0; i < v.hold; i++) begin
      @(negedge clk);
      check($sformatf("v%0d_hold_valid", idx), cpu_rsp_valid, 1'b1);
      check($sformatf("v%0d_hold_data", idx), cpu_rsp_data, v.data);
    end
    cpu_rsp_ready = 1;
    @(posedge clk); #1;
    cpu_rsp_ready = 0;
    check($sformatf("v%0d_mem_reqs", idx), mem_req_count - mr0, v.miss);
    check($sformatf("v%0d_tag_writes", idx), tag_wr_count - tw0, v.miss);
    check($sformatf("v%0d_data_writes", idx), data_wr_count - dw0, v.miss);
    if (v.miss) begin
      check($sformatf("v%0d_mem_addr", idx), mem_seen_addr, v.maddr);
      check($sformatf("v%0d_tag_set", idx), last_set, v.set);
      check($sformatf("v%0d_tag_wdata", idx), last_wdata, v.twd);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[9];
    vec_t v;
    int n, tw0, dw0;

    for (int i = 0; i < 64; i++) begin tag_mem[i] = '0; data_mem[i] = '0; end
    rst = 1; cpu_req_valid = 0; cpu_req_addr = '0; cpu_rsp_ready = 0; fence_i = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("rst_req_ready", cpu_req_ready, 1'b1);
    check("rst_rsp_valid", cpu_rsp_valid, 1'b0);
    check("rst_rsp_data", cpu_rsp_data, 32'h0);
    check("rst_mem_req_valid", mem_req_valid, 1'b0);
    check("rst_mem_req_addr", mem_req_addr, 32'h0);
    check("rst_tag_wen", tag_wen, 1'b0);
    check("rst_data_wen", data_wen, 1'b0);
    check("rst_fence_done", fence_done, 1'b0);
    check("rst_state", dbg_state, 3'd0);

    //         addr          beat0                  beat1                  miss data          maddr         set twd         dly hold
    vecs[0] = '{32'h8000_0010, 64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 1, 32'h3333_4444, 32'h8000_0010, 1, 23'h600000, 0, 0};
    vecs[1] = '{32'h8000_001C, 64'h0, 64'h0, 0, 32'h5555_6666, 32'h0, 0, 23'h0, 0, 0};
    vecs[2] = '{32'h8000_0014, 64'h0, 64'h0, 0, 32'h1111_2222, 32'h0, 0, 23'h0, 0, 0};
    vecs[3] = '{32'h8000_0018, 64'h0, 64'h0, 0, 32'h7777_8888, 32'h0, 0, 23'h0, 0, 1};
    vecs[4] = '{32'h8000_0410, 64'hAAAA_BBBB_CCCC_DDDD, 64'hEEEE_FFFF_0123_4567, 1, 32'hCCCC_DDDD, 32'h8000_0410, 1, 23'h600001, 0, 0};
    vecs[5] = '{32'h8000_0010, 64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 1, 32'h3333_4444, 32'h8000_0010, 1, 23'h600000, 0, 0};
    vecs[6] = '{32'h8000_002F, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1, 32'hFEDC_BA98, 32'h8000_0020, 2, 23'h600000, 5, 3};
    vecs[7] = '{32'h8000_0023, 64'h0, 64'h0, 0, 32'h89AB_CDEF, 32'h0, 0, 23'h0, 0, 0};
    vecs[8] = '{32'h8000_0018, 64'h0, 64'h0, 0, 32'h7777_8888, 32'h0, 0, 23'h0, 0, 0};
    for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

    // reset after refill beat 0: abandoned, no array writes, line re-fetched
    tw0 = tag_wr_count; dw0 = data_wr_count;
    abort_after_beat0 = 1;
    cur_b0 = 64'h0A0B_0C0D_0102_0304; cur_b1 = 64'h1020_3040_5060_7080;
    cur_maddr = 32'h8000_0030; cur_rdelay = 0;
    @(negedge clk);
    cpu_req_valid = 1; cpu_req_addr = 32'h8000_0030;
    @(posedge clk); #1 cpu_req_valid = 0;
    n = 0;
    do begin @(negedge clk); n++; end while (dbg_state != 3'd3 && n < 20);
    check("abort_reached_refill", dbg_state, 3'd3);
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    check("abort_state_idle", dbg_state, 3'd0);
    check("abort_req_ready", cpu_req_ready, 1'b1);
    check("abort_rsp_data", cpu_rsp_data, 32'h0);
    check("abort_tag_writes", tag_wr_count - tw0, 0);
    check("abort_data_writes", data_wr_count - dw0, 0);
    abort_after_beat0 = 0;
    v = '{32'h8000_0030, 64'h0A0B_0C0D_0102_0304, 64'h1020_3040_5060_7080, 1, 32'h0102_0304, 32'h8000_0030, 3, 23'h600000, 0, 0};
    run_vec(20, v);

    // fence_i together with a request: fence wins, no lookup
    tw0 = tag_wr_count; dw0 = data_wr_count; zero_seq = 0;
    @(negedge clk);
    fence_i = 1; cpu_req_valid = 1; cpu_req_addr = 32'h8000_0010;
    #1 check("fence_req_ready", cpu_req_ready, 1'b0);
    @(posedge clk); #1 cpu_req_valid = 0;
    n = 0;
    do begin
      @(negedge clk); n++;
      if (n == 1) begin
        check("fence_state", dbg_state, FENCE_STATE);
        fence_i = 0;
      end
    end while (!fence_done && n < 200);
    check("fence_latency", n, FENCE_LAT);
    @(negedge clk);
    check("fence_pulse_width", fence_done, 1'b0);
    check("fence_tag_writes", tag_wr_count - tw0, FENCE_WR);
    check("fence_zero_seq", zero_seq, FENCE_WR);
    check("fence_data_writes", data_wr_count - dw0, 0);
`ifdef YSYX_22050598_ICACHE_FENCE_EN
    v = '{32'h8000_0010, 64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 1, 32'h3333_4444, 32'h8000_0010, 1, 23'h600000, 0, 0};
`else
    v = '{32'h8000_0010, 64'h0, 64'h0, 0, 32'h3333_4444, 32'h0, 0, 23'h0, 0, 0};
`endif
    run_vec(30, v);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
